// File: rtl/bjack_pkg.sv
// bjack_pkg: state encoding, game constants and the BCD score helper shared by the autoplayer.
package bjack_pkg;
    typedef enum logic [2:0] {IDLE, STRT, SETTLE, EVAL, PRESS, GAP, ENDG, FIN} state_t;
    typedef enum logic [1:0] {END_BUST, END_HOLD, END_STAND} end_t;
    localparam int BJ_LIMIT = 21;
    localparam int BJ_DEALER_HOLD = 17;
    function automatic logic [5:0] bcd_to_bin(input logic [1:0] tens, input logic [3:0] units);
        return 6'(tens) * 6'd10 + 6'(units);
    endfunction
endpackage

// File: rtl/bjack_score_conv.sv
// bjack_score_conv: game score digits to a 6-bit binary score, flagging a non-BCD units digit.
module bjack_score_conv
    import bjack_pkg::*;
(
    input  logic [1:0] d_h,
    input  logic [3:0] d_l,
    output logic [5:0] score,
    output logic       invalid
);
    assign score = bcd_to_bin(d_h, d_l);
    assign invalid = d_l > 4'd9;
endmodule

// File: rtl/bjack_autoplayer.sv
// bjack_autoplayer: plays V_BJACK through its START/NEW_CARD pins, decides when to stand,
// and tallies bust/hold/stand outcomes over a batch of games.
module bjack_autoplayer
    import bjack_pkg::*;
#(
    parameter int START_LEN  = 4,
    parameter int SETTLE_LEN = 8,
    parameter int PRESS_LEN  = 2,
    parameter int GAP_LEN    = 8,
    parameter int STAND_AT   = BJ_DEALER_HOLD,
    parameter int MAX_CARDS  = 8,
    parameter int CNT_W      = 8
) (
    input  logic             SYS_CLK,
    input  logic             SYS_RES_N,
    input  logic             RUN,
    input  logic [7:0]       GAMES,
    input  logic [3:0]       D_L,
    input  logic [1:0]       D_H,
    input  logic             BUST,
    input  logic             HOLD,
    output logic             START,
    output logic             NEW_CARD,
    output logic             BUSY,
    output logic             DONE,
    output logic [CNT_W-1:0] N_BUST,
    output logic [CNT_W-1:0] N_HOLD,
    output logic [CNT_W-1:0] N_STAND,
    output logic             ERR
);
    state_t st, nxt;
    end_t kind;
    logic [7:0] tmr, rem, cards;
    logic [5:0] score;
    logic invalid, stand_now;

    bjack_score_conv u_conv (.d_h(D_H), .d_l(D_L), .score(score), .invalid(invalid));

    // a corrupt units digit is treated as a score high enough to stand
    assign stand_now = invalid || score >= 6'(STAND_AT) || cards == 8'(MAX_CARDS);

    always_comb begin
        nxt = st;
        case (st)
            IDLE:    if (RUN) nxt = (GAMES == 8'd0) ? FIN : STRT;
            STRT:    if (tmr == 8'(START_LEN - 1)) nxt = SETTLE;
            SETTLE:  if (tmr == 8'(SETTLE_LEN - 1)) nxt = EVAL;
            EVAL:    nxt = (BUST || HOLD || stand_now) ? ENDG : PRESS;
            PRESS:   if (tmr == 8'(PRESS_LEN - 1)) nxt = GAP;
            GAP:     if (tmr == 8'(GAP_LEN - 1)) nxt = EVAL;
            ENDG:    nxt = (rem == 8'd1 || !RUN) ? FIN : STRT;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge SYS_CLK or negedge SYS_RES_N) begin
        if (!SYS_RES_N) begin
            st       <= IDLE;
            kind     <= END_STAND;
            tmr      <= '0;
            rem      <= '0;
            cards    <= '0;
            START    <= 1'b1;
            NEW_CARD <= 1'b1;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            ERR      <= 1'b0;
            N_BUST   <= '0;
            N_HOLD   <= '0;
            N_STAND  <= '0;
        end else begin
            st       <= nxt;
            tmr      <= (nxt == st) ? tmr + 8'd1 : 8'd0;
            START    <= nxt != STRT;
            NEW_CARD <= nxt != PRESS;
            BUSY     <= !(nxt inside {IDLE, FIN});
            DONE     <= nxt == FIN;
            if (st == IDLE && RUN) begin
                rem     <= GAMES;
                ERR     <= 1'b0;
                N_BUST  <= '0;
                N_HOLD  <= '0;
                N_STAND <= '0;
            end
            if (st == STRT) cards <= '0;
            if (st == PRESS && nxt == GAP) cards <= cards + 8'd1;
            if (st == EVAL) begin
                ERR  <= ERR | invalid;
                kind <= BUST ? END_BUST : HOLD ? END_HOLD : END_STAND;
            end
            // outcome counters stick at full scale instead of wrapping
            if (st == ENDG) begin
                rem <= rem - 8'd1;
                if (kind == END_BUST && N_BUST != '1) N_BUST <= N_BUST + CNT_W'(1);
                if (kind == END_HOLD && N_HOLD != '1) N_HOLD <= N_HOLD + CNT_W'(1);
                if (kind == END_STAND && N_STAND != '1) N_STAND <= N_STAND + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_bjack_autoplayer.sv
// tb_bjack_autoplayer: autoplayer against a behavioural card game, with outcomes predicted
// from the game rules (score per card, flag thresholds, stand threshold, draw limit).
module tb_bjack_autoplayer;
    localparam int START_LEN  = 4;
    localparam int SETTLE_LEN = 8;
    localparam int PRESS_LEN  = 2;
    localparam int GAP_LEN    = 8;
    localparam int MAX_CARDS  = 8;
    localparam int CNT_W      = 8;
    // stand threshold above 21 so a 10-per-card game can reach its bust
    localparam int STAND_AT   = bjack_pkg::BJ_LIMIT + 1;
    localparam int M_NONE = 0, M_HOLD = 1, M_BUST = 2;
    localparam int K_BUST = 0, K_HOLD = 1, K_STAND = 2;

    logic clk = 1'b0, rst_n = 1'b1, run = 1'b0;
    logic [7:0] games = 8'd0;
    logic [3:0] d_l;
    logic [1:0] d_h;
    logic bust, hold, start, new_card, busy, done, err;
    logic [CNT_W-1:0] n_bust, n_hold, n_stand;

    int inc = 1, mode = M_NONE, score = 0;
    logic force_err = 1'b0, nc_prev = 1'b1;
    int cmps = 0, errs = 0;
    int presses = 0, nc_run = 0, nc_hi = 0, nc_bad = 0, gap_bad = 0;
    int starts = 0, st_run = 0, st_bad = 0;
    logic had_press = 1'b0;

    always #5 clk = ~clk;

    bjack_autoplayer #(
        .START_LEN(START_LEN), .SETTLE_LEN(SETTLE_LEN), .PRESS_LEN(PRESS_LEN), .GAP_LEN(GAP_LEN),
        .STAND_AT(STAND_AT), .MAX_CARDS(MAX_CARDS), .CNT_W(CNT_W)
    ) dut (
        .SYS_CLK(clk), .SYS_RES_N(rst_n), .RUN(run), .GAMES(games), .D_L(d_l), .D_H(d_h),
        .BUST(bust), .HOLD(hold), .START(start), .NEW_CARD(new_card), .BUSY(busy), .DONE(done),
        .N_BUST(n_bust), .N_HOLD(n_hold), .N_STAND(n_stand), .ERR(err)
    );

    // game: START low deals a fresh hand, each NEW_CARD press adds inc to the score
    always @(posedge clk) begin
        if (!start) score <= 0;
        else if (nc_prev && !new_card) score <= score + inc;
        nc_prev <= new_card;
    end
    assign d_l  = force_err ? 4'hC : 4'(score % 10);
    assign d_h  = 2'(score / 10);
    assign bust = mode == M_BUST && score > 21;
    assign hold = mode == M_HOLD && score >= 17;

    // pin monitor: pulse widths, press count, high time between presses
    always @(negedge clk) begin
        if (!start) begin
            st_run++;
            had_press = 1'b0;
        end else if (st_run != 0) begin
            starts++;
            if (st_run != START_LEN) st_bad++;
            st_run = 0;
        end
        if (!new_card) begin
            if (nc_run == 0 && had_press && nc_hi < GAP_LEN + 1) gap_bad++;
            nc_run++;
        end else begin
            if (nc_run != 0) begin
                presses++;
                if (nc_run != PRESS_LEN) nc_bad++;
                had_press = 1'b1;
                nc_hi = 0;
                nc_run = 0;
            end
            nc_hi++;
        end
    end

    function automatic void predict(input int n, input int m, input logic fe, output int pr, output int kind);
        int s;
        pr = 0;
        kind = K_STAND;
        if (fe) return;
        for (int c = 0; c <= MAX_CARDS; c++) begin
            s = c * n;
            pr = c;
            if (m == M_BUST && s > 21) begin kind = K_BUST; return; end
            if (m == M_HOLD && s >= 17) begin kind = K_HOLD; return; end
            if (s >= STAND_AT || c == MAX_CARDS) begin kind = K_STAND; return; end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmps++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done; i++) @(negedge clk);
        chk("done_seen", 32'(done), 32'd1);
        run = 1'b0;
    endtask

    task automatic play(input int n, input int m, input logic fe);
        int pr, kind, p0, nb0, gb0, sb0;
        inc = n;
        mode = m;
        force_err = fe;
        predict(n, m, fe, pr, kind);
        p0 = presses; nb0 = nc_bad; gb0 = gap_bad; sb0 = st_bad;
        games = 8'd1;
        run = 1'b1;
        @(negedge clk);
        chk("start_low_next", 32'(start), 32'd0);
        chk("busy_set", 32'(busy), 32'd1);
        wait_done(3000);
        chk("busy_at_done", 32'(busy), 32'd0);
        chk("n_bust", 32'(n_bust), 32'(kind == K_BUST));
        chk("n_hold", 32'(n_hold), 32'(kind == K_HOLD));
        chk("n_stand", 32'(n_stand), 32'(kind == K_STAND));
        chk("presses", 32'(presses - p0), 32'(pr));
        chk("press_width", 32'(nc_bad - nb0), 32'd0);
        chk("gap_width", 32'(gap_bad - gb0), 32'd0);
        chk("start_width", 32'(st_bad - sb0), 32'd0);
        chk("err", 32'(err), 32'(fe));
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
        force_err = 1'b0;
    endtask

    initial begin
        int m, n, s0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_start", 32'(start), 32'd1);
        chk("rst_new_card", 32'(new_card), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_counts", 32'(n_bust) + 32'(n_hold) + 32'(n_stand), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // reset while START is mid-pulse
        games = 8'd3; inc = 1; mode = M_NONE; run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("midpulse_start_low", 32'(start), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("async_start_high", 32'(start), 32'd1);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_counts", 32'(n_bust) + 32'(n_hold) + 32'(n_stand), 32'd0);
        run = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_counts", 32'(n_bust) + 32'(n_hold) + 32'(n_stand), 32'd0);

        play(5, M_HOLD, 1'b0);
        play(10, M_BUST, 1'b0);
        play(1, M_NONE, 1'b0);
        play(7, M_NONE, 1'b1);
        repeat (3) @(negedge clk);
        chk("err_sticky", 32'(err), 32'd1);
        chk("stand_holds", 32'(n_stand), 32'd1);

        // empty batch: no START pulse, DONE next cycle, counters and ERR cleared
        s0 = starts;
        games = 8'd0; run = 1'b1;
        @(negedge clk);
        chk("g0_done", 32'(done), 32'd1);
        chk("g0_start", 32'(start), 32'd1);
        chk("g0_busy", 32'(busy), 32'd0);
        run = 1'b0;
        @(negedge clk);
        chk("g0_done_pulse", 32'(done), 32'd0);
        chk("g0_counts", 32'(n_bust) + 32'(n_hold) + 32'(n_stand), 32'd0);
        chk("g0_err", 32'(err), 32'd0);
        chk("g0_no_start", 32'(starts - s0), 32'd0);

        // RUN dropped during game 2 of 5
        s0 = starts;
        inc = 5; mode = M_HOLD; games = 8'd5; run = 1'b1;
        for (int i = 0; i < 1000 && !(starts - s0 >= 1 && !start); i++) @(negedge clk);
        chk("game2_started", 32'(starts - s0 >= 1 && !start), 32'd1);
        run = 1'b0;
        wait_done(3000);
        chk("drop_hold", 32'(n_hold), 32'd2);
        chk("drop_sum", 32'(n_bust) + 32'(n_hold) + 32'(n_stand), 32'd2);
        chk("drop_starts", 32'(starts - s0), 32'd2);
        @(negedge clk);

        for (int g = 0; g < 12; g++) begin
            m = int'($urandom_range(2, 0));
            n = (m == M_NONE) ? int'($urandom_range(4, 1)) : int'($urandom_range(10, 1));
            play(n, m, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
        $finish;
    end
endmodule
